sc_game_statemachine: RTL and testbench
=======================================

SC_GAME_STATEMACHINE -- requirements
Module: sc_game_statemachine

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-low reset; all state changes on the rising edge of SC_GAME_STATEMACHINE_CLOCK_50.
REQ-002 Parameter LIVES_INIT, default 3, SHALL set the lives loaded at reset and at game start (range 1-3).
REQ-003 Parameter TICKS_PER_LEVEL, default 16, SHALL set the tick pulses per level step (range 2-255).
REQ-004 Parameter HIT_HOLD, default 8, SHALL set the tick pulses of invulnerability after a hit (range 1-255).
REQ-005 Parameter LEVEL_MAX, default 7, SHALL set the level saturation value (range 1-7).
REQ-006 SC_GAME_STATEMACHINE_CLOCK_50  in  1  system clock.
REQ-007 SC_GAME_STATEMACHINE_RESET_InLow  in  1  synchronous reset, active low.
REQ-008 SC_GAME_STATEMACHINE_COLLISION_InLow  in  1  collision flag from the collision detector, low = point overlaps background.
REQ-009 SC_GAME_STATEMACHINE_START_InLow  in  1  debounced start button, low = pressed.
REQ-010 SC_GAME_STATEMACHINE_TICK_In  in  1  one-cycle game-speed pulse from the prescaler.
REQ-011 SC_GAME_STATEMACHINE_CLEAR_OutLow  out  1  one-cycle low pulse clearing the background register.
REQ-012 SC_GAME_STATEMACHINE_SHIFT_OutHigh  out  1  one-cycle high pulse advancing the background register.
REQ-013 SC_GAME_STATEMACHINE_LIVES_OutBUS  out  2  remaining lives.
REQ-014 SC_GAME_STATEMACHINE_LEVEL_OutBUS  out  3  current level.
REQ-015 SC_GAME_STATEMACHINE_STATE_OutBUS  out  2  state code: IDLE=00, PLAY=01, HIT=10, GAMEOVER=11.
REQ-016 SC_GAME_STATEMACHINE_GAMEOVER_OutHigh  out  1  high while in GAMEOVER.
REQ-017 SC_GAME_STATEMACHINE_BLINK_OutHigh  out  1  point-display blink, toggles during HIT.

Function
REQ-018 All outputs SHALL be registered; each response appears on the clock edge that samples its cause (one-cycle latency).
REQ-019 A start event SHALL be a high-to-low transition of START_InLow, detected against a registered previous sample; a held-low level SHALL produce only one event.
REQ-020 IDLE: start event -> PLAY; same edge CLEAR_OutLow low one cycle, lives = LIVES_INIT, level = 0, tick and hit counters = 0; TICK_In and COLLISION_InLow ignored.
REQ-021 PLAY: each TICK_In -> SHIFT_OutHigh high one cycle, tick counter +1; at count TICKS_PER_LEVEL-1 plus tick -> counter 0, level +1, saturating at LEVEL_MAX.
REQ-022 PLAY: COLLISION_InLow low sampled with lives > 1 -> lives -1, HIT, hit counter 0, BLINK = 1.
REQ-023 PLAY: COLLISION_InLow low sampled with lives == 1 -> lives 0, GAMEOVER.
REQ-024 PLAY: collision and tick in the same cycle -> both SHALL apply (shift pulse, tick/level counting) with the collision deciding the next state.
REQ-025 HIT: COLLISION_InLow ignored; SHIFT and level counting continue as in PLAY; each tick toggles BLINK and increments hit counter; on the HIT_HOLD-th tick -> PLAY, BLINK = 0.
REQ-026 GAMEOVER: SHIFT_OutHigh 0, GAMEOVER_OutHigh 1, lives 0, level held; TICK_In ignored; start event -> IDLE with GAMEOVER_OutHigh 0.
REQ-027 Lives SHALL never underflow below 0 and the level SHALL never exceed LEVEL_MAX.
REQ-028 CLEAR_OutLow SHALL be 1 in every cycle other than the IDLE->PLAY transition cycle.

Reset
REQ-029 RESET_InLow low at a clock edge SHALL override all inputs and force: state IDLE, lives LIVES_INIT, level 0, counters 0, CLEAR_OutLow 1, SHIFT_OutHigh 0, GAMEOVER_OutHigh 0, BLINK_OutHigh 0, previous-start register 1.
REQ-030 Reset mid-game (any state) SHALL apply REQ-029 on the next edge; a START_InLow held low through reset release SHALL NOT produce a start event until released and pressed again.

Verification
REQ-031 Reset, START press -> state 01, CLEAR_OutLow low exactly one cycle, lives 3, level 0.
REQ-032 PLAY, 16 ticks, no collision -> 16 SHIFT pulses, level 1; 112+ further ticks -> level saturates at 7.
REQ-033 PLAY lives 3, COLLISION_InLow low 1 cycle -> lives 2, state 10; collisions during HIT ignored; after 8 ticks BLINK toggled 8 times, ends 0, state 01.
REQ-034 Lives 1, collision coincident with tick -> SHIFT pulse issued, lives 0, state 11, GAMEOVER 1; further ticks -> no SHIFT.
REQ-035 GAMEOVER, START held low -> single transition to IDLE only; release and press -> PLAY with lives 3, level 0.
REQ-036 Reset asserted in HIT with START held low -> IDLE, all outputs at reset values, no PLAY entry until START released and pressed.

Source files
------------

// File: rtl/sc_game_statemachine_if.sv
// Game controller bus: collision/start/tick inputs and the registered
// background-register, score and status outputs.
interface sc_game_statemachine_if;
   logic       SC_GAME_STATEMACHINE_COLLISION_InLow;
   logic       SC_GAME_STATEMACHINE_START_InLow;
   logic       SC_GAME_STATEMACHINE_TICK_In;
   logic       SC_GAME_STATEMACHINE_CLEAR_OutLow;
   logic       SC_GAME_STATEMACHINE_SHIFT_OutHigh;
   logic [1:0] SC_GAME_STATEMACHINE_LIVES_OutBUS;
   logic [2:0] SC_GAME_STATEMACHINE_LEVEL_OutBUS;
   logic [1:0] SC_GAME_STATEMACHINE_STATE_OutBUS;
   logic       SC_GAME_STATEMACHINE_GAMEOVER_OutHigh;
   logic       SC_GAME_STATEMACHINE_BLINK_OutHigh;

   modport master (
      output SC_GAME_STATEMACHINE_COLLISION_InLow,
      output SC_GAME_STATEMACHINE_START_InLow,
      output SC_GAME_STATEMACHINE_TICK_In,
      input  SC_GAME_STATEMACHINE_CLEAR_OutLow,
      input  SC_GAME_STATEMACHINE_SHIFT_OutHigh,
      input  SC_GAME_STATEMACHINE_LIVES_OutBUS,
      input  SC_GAME_STATEMACHINE_LEVEL_OutBUS,
      input  SC_GAME_STATEMACHINE_STATE_OutBUS,
      input  SC_GAME_STATEMACHINE_GAMEOVER_OutHigh,
      input  SC_GAME_STATEMACHINE_BLINK_OutHigh
   );

   modport slave (
      input  SC_GAME_STATEMACHINE_COLLISION_InLow,
      input  SC_GAME_STATEMACHINE_START_InLow,
      input  SC_GAME_STATEMACHINE_TICK_In,
      output SC_GAME_STATEMACHINE_CLEAR_OutLow,
      output SC_GAME_STATEMACHINE_SHIFT_OutHigh,
      output SC_GAME_STATEMACHINE_LIVES_OutBUS,
      output SC_GAME_STATEMACHINE_LEVEL_OutBUS,
      output SC_GAME_STATEMACHINE_STATE_OutBUS,
      output SC_GAME_STATEMACHINE_GAMEOVER_OutHigh,
      output SC_GAME_STATEMACHINE_BLINK_OutHigh
   );
endinterface

// File: rtl/sc_game_statemachine.sv
// Game sequencer: start/play/hit/game-over control with lives, level and
// invulnerability timing; every output is registered.
//
// state    | meaning
// ---------+---------------------------------------------------------------
// IDLE     | waiting for a start press; lives/level held
// PLAY     | background shifts on tick; collision costs a life
// HIT      | invulnerable for HIT_HOLD ticks, blink toggles, shifting continues
// GAMEOVER | no lives left; shifting stops until the next start press
module sc_game_statemachine #(
   parameter int LIVES_INIT      = 3,
   parameter int TICKS_PER_LEVEL = 16,
   parameter int HIT_HOLD        = 8,
   parameter int LEVEL_MAX       = 7
) (
   input  logic                  SC_GAME_STATEMACHINE_CLOCK_50,
   input  logic                  SC_GAME_STATEMACHINE_RESET_InLow,
   sc_game_statemachine_if.slave gameBus
);

   typedef enum logic [1:0] {
      IDLE     = 2'b00,
      PLAY     = 2'b01,
      HIT      = 2'b10,
      GAMEOVER = 2'b11
   } stateType;

   localparam logic [1:0] LIVES_LOAD = 2'(LIVES_INIT);
   localparam logic [7:0] TICK_LAST  = 8'(TICKS_PER_LEVEL - 1);
   localparam logic [7:0] HIT_LAST   = 8'(HIT_HOLD - 1);
   localparam logic [2:0] LEVEL_TOP  = 3'(LEVEL_MAX);

   stateType   stateReg, stateNxt;
   logic [1:0] livesReg, livesNxt;
   logic [2:0] levelReg, levelNxt;
   logic [7:0] tickCnt, tickCntNxt;
   logic [7:0] hitCnt, hitCntNxt;
   logic       clearReg, clearNxt;
   logic       shiftReg, shiftNxt;
   logic       blinkReg, blinkNxt;
   logic       gameoverReg, gameoverNxt;
   logic       startPrev;
   logic       startArmed;
   logic       startEvent;

   logic collisionIn, startIn, tickIn;
   assign collisionIn = gameBus.SC_GAME_STATEMACHINE_COLLISION_InLow;
   assign startIn     = gameBus.SC_GAME_STATEMACHINE_START_InLow;
   assign tickIn      = gameBus.SC_GAME_STATEMACHINE_TICK_In;

   // startArmed stays low until START has been seen high, so a button held
   // through reset release cannot masquerade as a fresh press.
   assign startEvent = startArmed & startPrev & ~startIn;

   // State and output registers.
   always_ff @(posedge SC_GAME_STATEMACHINE_CLOCK_50) begin
      if (!SC_GAME_STATEMACHINE_RESET_InLow) begin
         stateReg    <= IDLE;
         livesReg    <= LIVES_LOAD;
         levelReg    <= 3'd0;
         tickCnt     <= 8'd0;
         hitCnt      <= 8'd0;
         clearReg    <= 1'b1;
         shiftReg    <= 1'b0;
         blinkReg    <= 1'b0;
         gameoverReg <= 1'b0;
         startPrev   <= 1'b1;
         startArmed  <= startIn;
      end else begin
         stateReg    <= stateNxt;
         livesReg    <= livesNxt;
         levelReg    <= levelNxt;
         tickCnt     <= tickCntNxt;
         hitCnt      <= hitCntNxt;
         clearReg    <= clearNxt;
         shiftReg    <= shiftNxt;
         blinkReg    <= blinkNxt;
         gameoverReg <= gameoverNxt;
         startPrev   <= startIn;
         startArmed  <= startArmed | startIn;
      end
   end

   // Next-state decision.
   always_comb begin
      stateNxt = stateReg;
      case (stateReg)
         IDLE:     if (startEvent) stateNxt = PLAY;
         PLAY:     if (!collisionIn) stateNxt = (livesReg > 2'd1) ? HIT : GAMEOVER;
         HIT:      if (tickIn && (hitCnt == HIT_LAST)) stateNxt = PLAY;
         GAMEOVER: if (startEvent) stateNxt = IDLE;
         default:  stateNxt = IDLE;
      endcase
   end

   // Registered-output and counter updates.
   always_comb begin
      livesNxt    = livesReg;
      levelNxt    = levelReg;
      tickCntNxt  = tickCnt;
      hitCntNxt   = hitCnt;
      clearNxt    = 1'b1;
      shiftNxt    = 1'b0;
      blinkNxt    = blinkReg;
      gameoverNxt = (stateNxt == GAMEOVER);

      // Shifting and level progression are shared by PLAY and HIT.
      if ((stateReg == PLAY || stateReg == HIT) && tickIn) begin
         shiftNxt = 1'b1;
         if (tickCnt == TICK_LAST) begin
            tickCntNxt = 8'd0;
            levelNxt   = (levelReg >= LEVEL_TOP) ? LEVEL_TOP : levelReg + 3'd1;
         end else begin
            tickCntNxt = tickCnt + 8'd1;
         end
      end

      case (stateReg)
         IDLE: begin
            if (startEvent) begin
               clearNxt   = 1'b0;
               livesNxt   = LIVES_LOAD;
               levelNxt   = 3'd0;
               tickCntNxt = 8'd0;
               hitCntNxt  = 8'd0;
               blinkNxt   = 1'b0;
            end
         end
         PLAY: begin
            if (!collisionIn) begin
               if (livesReg > 2'd1) begin
                  livesNxt  = livesReg - 2'd1;
                  hitCntNxt = 8'd0;
                  blinkNxt  = 1'b1;
               end else begin
                  livesNxt  = 2'd0;
                  blinkNxt  = 1'b0;
               end
            end
         end
         HIT: begin
            if (tickIn) begin
               if (hitCnt == HIT_LAST) begin
                  hitCntNxt = 8'd0;
                  blinkNxt  = 1'b0;
               end else begin
                  hitCntNxt = hitCnt + 8'd1;
                  blinkNxt  = ~blinkReg;
               end
            end
         end
         GAMEOVER: begin
            livesNxt = 2'd0;
            blinkNxt = 1'b0;
         end
         default: ;
      endcase
   end

   assign gameBus.SC_GAME_STATEMACHINE_CLEAR_OutLow     = clearReg;
   assign gameBus.SC_GAME_STATEMACHINE_SHIFT_OutHigh    = shiftReg;
   assign gameBus.SC_GAME_STATEMACHINE_LIVES_OutBUS     = livesReg;
   assign gameBus.SC_GAME_STATEMACHINE_LEVEL_OutBUS     = levelReg;
   assign gameBus.SC_GAME_STATEMACHINE_STATE_OutBUS     = stateReg;
   assign gameBus.SC_GAME_STATEMACHINE_GAMEOVER_OutHigh = gameoverReg;
   assign gameBus.SC_GAME_STATEMACHINE_BLINK_OutHigh    = blinkReg;

endmodule

// File: tb/tb_sc_game_statemachine.sv
// Scoreboard bench for sc_game_statemachine: directed per-cycle stimulus
// pushes hand-derived expectations; a monitor compares after each edge.
module tb_sc_game_statemachine;

   logic clk;
   logic rstB;
   int   testsRun;
   int   testsFailed;

   sc_game_statemachine_if gameBus();

   sc_game_statemachine dut (
      .SC_GAME_STATEMACHINE_CLOCK_50   (clk),
      .SC_GAME_STATEMACHINE_RESET_InLow(rstB),
      .gameBus                         (gameBus.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [10:0] exp;
      logic [10:0] mask;
      string       name;
   } expEntry;

   expEntry sbQ[$];

   localparam logic [10:0] ALL   = 11'h7FF;
   localparam logic [10:0] NOSCO = 11'h60F;

   // {clear, shift, lives, level, state, gameover, blink}
   function automatic logic [10:0] pk(logic c, logic s, logic [1:0] l,
                                      logic [2:0] lv, logic [1:0] st,
                                      logic g, logic b);
      return {c, s, l, lv, st, g, b};
   endfunction

   function automatic logic [10:0] actual();
      return {gameBus.SC_GAME_STATEMACHINE_CLEAR_OutLow,
              gameBus.SC_GAME_STATEMACHINE_SHIFT_OutHigh,
              gameBus.SC_GAME_STATEMACHINE_LIVES_OutBUS,
              gameBus.SC_GAME_STATEMACHINE_LEVEL_OutBUS,
              gameBus.SC_GAME_STATEMACHINE_STATE_OutBUS,
              gameBus.SC_GAME_STATEMACHINE_GAMEOVER_OutHigh,
              gameBus.SC_GAME_STATEMACHINE_BLINK_OutHigh};
   endfunction

   task automatic step(input logic rst, input logic st, input logic co,
                       input logic tk, input logic [10:0] e,
                       input logic [10:0] m, input string nm);
      expEntry ent;
      @(negedge clk);
      rstB = rst;
      gameBus.SC_GAME_STATEMACHINE_START_InLow     = st;
      gameBus.SC_GAME_STATEMACHINE_COLLISION_InLow = co;
      gameBus.SC_GAME_STATEMACHINE_TICK_In         = tk;
      ent.exp  = e;
      ent.mask = m;
      ent.name = nm;
      sbQ.push_back(ent);
   endtask

   // Monitor: one popped expectation per edge, compared 1 time unit later.
   initial begin
      expEntry ent;
      logic [10:0] act;
      forever begin
         @(posedge clk);
         #1;
         if (sbQ.size() > 0) begin
            ent = sbQ.pop_front();
            act = actual();
            testsRun++;
            if (((act ^ ent.exp) & ent.mask) != 11'd0) begin
               testsFailed++;
               $display("FAIL %s: got c/s/lives/lvl/st/go/bl=%b_%b_%0d_%0d_%0d_%b_%b expected %b_%b_%0d_%0d_%0d_%b_%b",
                        ent.name, act[10], act[9], act[8:7], act[6:4], act[3:2], act[1], act[0],
                        ent.exp[10], ent.exp[9], ent.exp[8:7], ent.exp[6:4], ent.exp[3:2],
                        ent.exp[1], ent.exp[0]);
            end
         end
      end
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [2:0] lv;
      logic       bl;
      testsRun    = 0;
      testsFailed = 0;
      rstB = 1'b0;
      gameBus.SC_GAME_STATEMACHINE_START_InLow     = 1'b1;
      gameBus.SC_GAME_STATEMACHINE_COLLISION_InLow = 1'b1;
      gameBus.SC_GAME_STATEMACHINE_TICK_In         = 1'b0;

      // Reset and idle; tick/collision ignored in IDLE.
      step(0, 1, 1, 0, pk(1,0,3,0,0,0,0), ALL, "reset");
      step(0, 1, 1, 0, pk(1,0,3,0,0,0,0), ALL, "reset_hold");
      step(1, 1, 1, 0, pk(1,0,3,0,0,0,0), ALL, "idle");
      step(1, 1, 0, 1, pk(1,0,3,0,0,0,0), ALL, "idle_ignores_tick_coll");

      // Start press, clear pulse exactly one cycle.
      step(1, 0, 1, 0, pk(0,0,3,0,1,0,0), ALL, "start_clear");
      step(1, 0, 1, 0, pk(1,0,3,0,1,0,0), ALL, "clear_one_cycle");

      // 16 spaced ticks: 16 shift pulses, level 1.
      for (int i = 1; i <= 16; i++) begin
         lv = (i == 16) ? 3'd1 : 3'd0;
         step(1, 1, 1, 1, pk(1,1,3,lv,1,0,0), ALL, "play_tick");
         step(1, 1, 1, 0, pk(1,0,3,lv,1,0,0), ALL, "play_gap");
      end

      // Back-to-back ticks up to 130 total: level saturates at 7.
      for (int n = 17; n <= 130; n++) begin
         lv = (n / 16 > 7) ? 3'd7 : 3'(n / 16);
         step(1, 1, 1, 1, pk(1,1,3,lv,1,0,0), ALL, "level_count");
      end
      step(1, 1, 1, 0, pk(1,0,3,7,1,0,0), ALL, "level_sat");

      // Collision with 3 lives; collisions during HIT ignored.
      step(1, 1, 0, 0, pk(1,0,2,7,2,0,1), ALL, "hit_entry");
      for (int k = 1; k <= 8; k++) begin
         bl = (k < 8) ? ((k % 2) == 0) : 1'b0;
         step(1, 1, 1, 1, pk(1,1,2,7,(k == 8) ? 2'd1 : 2'd2,0,bl), ALL, "hit_tick");
         if (k < 8)
            step(1, 1, 0, 0, pk(1,0,2,7,2,0,bl), ALL, "hit_ignores_coll");
      end
      step(1, 1, 1, 0, pk(1,0,2,7,1,0,0), ALL, "hit_exit");

      // Second hit, back-to-back ticks.
      step(1, 1, 0, 0, pk(1,0,1,7,2,0,1), ALL, "hit2_entry");
      for (int k = 1; k <= 8; k++) begin
         bl = (k < 8) ? ((k % 2) == 0) : 1'b0;
         step(1, 1, 1, 1, pk(1,1,1,7,(k == 8) ? 2'd1 : 2'd2,0,bl), ALL, "hit2_tick");
      end

      // Last life: collision with tick -> shift still issued, GAMEOVER.
      step(1, 1, 0, 1, pk(1,1,0,7,3,1,0), ALL, "gameover_entry");
      for (int k = 0; k < 3; k++)
         step(1, 1, 1, 1, pk(1,0,0,7,3,1,0), ALL, "gameover_no_shift");

      // Held start: single transition to IDLE only.
      step(1, 0, 1, 0, pk(1,0,0,7,0,0,0), NOSCO, "gameover_to_idle");
      step(1, 0, 1, 0, pk(1,0,0,7,0,0,0), NOSCO, "held_start_idle");
      step(1, 0, 1, 0, pk(1,0,0,7,0,0,0), NOSCO, "held_start_idle");
      step(1, 1, 1, 0, pk(1,0,0,7,0,0,0), NOSCO, "release_idle");
      step(1, 0, 1, 0, pk(0,0,3,0,1,0,0), ALL, "restart");
      step(1, 1, 1, 0, pk(1,0,3,0,1,0,0), ALL, "restart_clear_end");

      // Tick counter cleared on restart.
      for (int i = 1; i <= 16; i++) begin
         lv = (i == 16) ? 3'd1 : 3'd0;
         step(1, 1, 1, 1, pk(1,1,3,lv,1,0,0), ALL, "restart_tick");
      end

      // Reset during HIT with START held low.
      step(1, 1, 0, 0, pk(1,0,2,1,2,0,1), ALL, "hit3_entry");
      step(1, 0, 1, 0, pk(1,0,2,1,2,0,1), ALL, "hit3_start_ignored");
      step(0, 0, 1, 1, pk(1,0,3,0,0,0,0), ALL, "reset_in_hit");
      step(0, 0, 0, 1, pk(1,0,3,0,0,0,0), ALL, "reset_in_hit_hold");
      for (int k = 0; k < 3; k++)
         step(1, 0, 1, 0, pk(1,0,3,0,0,0,0), ALL, "no_start_after_reset");
      step(1, 1, 1, 0, pk(1,0,3,0,0,0,0), ALL, "release_after_reset");
      step(1, 0, 1, 0, pk(0,0,3,0,1,0,0), ALL, "press_after_reset");
      step(1, 1, 1, 0, pk(1,0,3,0,1,0,0), ALL, "play_after_reset");

      @(negedge clk);
      @(negedge clk);
      testsRun++;
      if (sbQ.size() != 0) begin
         testsFailed++;
         $display("FAIL sb_drain: %0d entries left, expected 0", sbQ.size());
      end

      $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
      $finish;
   end

endmodule
